// File: rtl/wb_stage_ctrl.sv
// wb_stage_ctrl: registered MEM/WB writeback stage.
// Holds one MEM/WB entry, stalls on loads until memory data returns, and
// selects register-file write data by the held opcode class.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   MEM-stage handshake (ready low only while a load waits)
//   flush                 kill held/incoming entry (next state EMPTY)
//   instr                 instruction word, opcode = instr[15:11]
//   wr_en_in, waddr_in    destination write enable / register
//   alu_result, rs,
//   pc_add2               candidate write-back operands
//   flag_zero/lt/lte/ovf  compare/carry flags
//   mem_rvalid, mem_rdata load data return
//   rf_we, rf_waddr,
//   rf_wdata              register-file write port
//   fwd_valid             forwarding entry valid (equals rf_we)
//   stall_cnt             saturating count of cycles stalled in WAIT_MEM
module wb_stage_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [15:0]       instr,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] pc_add2,
  input  logic              flag_zero,
  input  logic              flag_lt,
  input  logic              flag_lte,
  input  logic              flag_ovf,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_FULL     = 2'd2
  } state_t;

  localparam logic [4:0] OP_LD = 5'b10001;

  state_t              state;
  logic [4:0]          op_q;
  logic [7:0]          imm_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   alu_q;
  logic [DATA_W-1:0]   rs_q;
  logic [DATA_W-1:0]   pc_q;
  logic [DATA_W-1:0]   mem_q;
  logic [3:0]          flags_q;   // {ovf, lte, lt, zero}
  logic [DATA_W-1:0]   btr_val;

  // instr[10:8] carries register specifiers not needed at writeback.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[10:8];

  assign in_ready  = (state != S_WAIT_MEM);
  assign rf_we     = (state == S_FULL) && wr_en_q;
  assign fwd_valid = rf_we;
  assign rf_waddr  = waddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      op_q      <= '0;
      imm_q     <= '0;
      wr_en_q   <= 1'b0;
      waddr_q   <= '0;
      alu_q     <= '0;
      rs_q      <= '0;
      pc_q      <= '0;
      mem_q     <= '0;
      flags_q   <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_WAIT_MEM: begin
          if (mem_rvalid) begin
            mem_q <= mem_rdata;
            state <= S_FULL;
          end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        default: begin
          // EMPTY or FULL: in_ready is high and flush is low here, so
          // in_valid alone means accept. A FULL entry always retires.
          if (in_valid) begin
            op_q    <= instr[15:11];
            imm_q   <= instr[7:0];
            wr_en_q <= wr_en_in;
            waddr_q <= waddr_in;
            alu_q   <= alu_result;
            rs_q    <= rs;
            pc_q    <= pc_add2;
            flags_q <= {flag_ovf, flag_lte, flag_lt, flag_zero};
            if (instr[15:11] == OP_LD) begin
              if (mem_rvalid) begin
                mem_q <= mem_rdata;
                state <= S_FULL;
              end else begin
                state <= S_WAIT_MEM;
              end
            end else begin
              state <= S_FULL;
            end
          end else begin
            state <= S_EMPTY;
          end
        end
      endcase
    end
  end

  always_comb begin
    btr_val = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      btr_val[i] = rs_q[DATA_W-1-i];
    end
  end

  always_comb begin
    rf_wdata = alu_q;
    casez (op_q)
      5'b010??, 5'b101??, 5'b10011, 5'b11010, 5'b11011: rf_wdata = alu_q;
      5'b11000: rf_wdata = {{(DATA_W-8){imm_q[7]}}, imm_q};
      5'b11001: rf_wdata = btr_val;
      5'b10010: rf_wdata = {rs_q[DATA_W-9:0], imm_q};
      5'b10001: rf_wdata = mem_q;
      5'b11100: rf_wdata = {{(DATA_W-1){1'b0}}, flags_q[0]};
      5'b11101: rf_wdata = {{(DATA_W-1){1'b0}}, flags_q[1]};
      5'b11110: rf_wdata = {{(DATA_W-1){1'b0}}, flags_q[2]};
      5'b11111: rf_wdata = {{(DATA_W-1){1'b0}}, flags_q[3]};
      5'b00110, 5'b00111: rf_wdata = pc_q;
      default: rf_wdata = alu_q;
    endcase
  end

endmodule
